// File: rtl/interrupt_unit_n.sv
// Interrupt unit: latches source event pulses, arbitrates them and
// commits one flag per cycle into the CPU interrupt register.
module interrupt_unit_n #(
    parameter int NSRC    = 3,
    parameter int RR_MODE = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] ienable,
    input  logic [NSRC-1:0] irqstd,
    input  logic [NSRC-1:0] evt,
    input  logic            lostclr,
    output logic            activintreg,
    output logic [NSRC-1:0] irqset,
    output logic [NSRC-1:0] irqlost,
    output logic            irq
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        COMMIT = 2'b10
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pend_n;
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] gnt;
    logic [NSRC-1:0] gnt_fix;
    logic [NSRC-1:0] gnt_rr;
    logic [NSRC-1:0] evt_ok;
    logic [NSRC-1:0] lost_set;
    logic [NSRC-1:0] lost_n;
    logic [NSRC-1:0] set_n;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   gidx_fix;
    logic [IW-1:0]   gidx_rr;
    logic            act_n;

    assign irq    = |irqstd;
    assign elig   = pend & ienable & ~irqstd;
    assign evt_ok = evt & ienable;

    // irqstd lags the strobe by one cycle, so mask the flag being committed
    always_comb begin
        cand = '0;
        case (state)
            IDLE:    cand = elig;
            COMMIT:  cand = elig & ~irqset;
            default: cand = '0;
        endcase
    end

    always_comb begin
        gnt_fix  = '0;
        gidx_fix = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                gnt_fix    = '0;
                gnt_fix[i] = 1'b1;
                gidx_fix   = IW'(i);
            end
        end
    end

    always_comb begin
        logic [CW-1:0] s;
        logic          hit;
        gnt_rr  = '0;
        gidx_rr = '0;
        hit     = 1'b0;
        s       = '0;
        for (int k = 1; k <= NSRC; k++) begin
            s = {1'b0, ptr} + CW'(k);
            if (s >= CW'(NSRC))
                s = s - CW'(NSRC);
            if (!hit && cand[s[IW-1:0]]) begin
                hit                = 1'b1;
                gnt_rr[s[IW-1:0]]  = 1'b1;
                gidx_rr            = s[IW-1:0];
            end
        end
    end

    assign gnt  = (RR_MODE != 0) ? gnt_rr : gnt_fix;
    assign gidx = (RR_MODE != 0) ? gidx_rr : gidx_fix;

    // a fresh event beats the grant-clear of the same edge
    assign pend_n   = (evt_ok & ~irqstd)
                    | (pend & ~gnt & ienable & ~irqstd);
    assign lost_set = evt_ok & (irqstd | (pend & ~gnt));
    assign lost_n   = lostclr ? lost_set : (irqlost | lost_set);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = (|cand) ? COMMIT : IDLE;
            COMMIT:  state_n = (|cand) ? COMMIT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        act_n = 1'b0;
        set_n = '0;
        case (state)
            IDLE, COMMIT: begin
                act_n = |gnt;
                set_n = gnt;
            end
            default: begin
                act_n = 1'b0;
                set_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend        <= '0;
            ptr         <= '0;
            activintreg <= 1'b0;
            irqset      <= '0;
            irqlost     <= '0;
        end else begin
            pend        <= pend_n;
            activintreg <= act_n;
            irqset      <= set_n;
            irqlost     <= lost_n;
            if (|gnt)
                ptr <= gidx;
        end
    end

endmodule

// File: tb/tb_interrupt_unit_n.sv
// Directed bench for interrupt_unit_n: fixed-priority and
// round-robin instances driven by hand-computed vectors.
module tb_interrupt_unit_n;

    logic       clock;
    logic       reset;
    logic [2:0] ienable_a, irqstd_a, evt_a;
    logic       lostclr;
    logic       act_a;
    logic [2:0] set_a, lost_a;
    logic       irq_a;
    logic [2:0] ienable_b, irqstd_b, evt_b;
    logic       act_b;
    logic [2:0] set_b, lost_b;
    logic       irq_b;

    int checks = 0;
    int errors = 0;

    interrupt_unit_n #(.NSRC(3), .RR_MODE(0)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .ienable     (ienable_a),
        .irqstd      (irqstd_a),
        .evt         (evt_a),
        .lostclr     (lostclr),
        .activintreg (act_a),
        .irqset      (set_a),
        .irqlost     (lost_a),
        .irq         (irq_a)
    );

    interrupt_unit_n #(.NSRC(3), .RR_MODE(1)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .ienable     (ienable_b),
        .irqstd      (irqstd_b),
        .evt         (evt_b),
        .lostclr     (1'b0),
        .activintreg (act_b),
        .irqset      (set_b),
        .irqlost     (lost_b),
        .irq         (irq_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [2:0] obs,
                         input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        lostclr   = 1'b0;
        ienable_a = 3'b000;
        irqstd_a  = 3'b000;
        evt_a     = 3'b000;
        ienable_b = 3'b111;
        irqstd_b  = 3'b000;
        evt_b     = 3'b000;
        #3;
        chk_b("rst_act", act_a, 1'b0);
        chk_v("rst_set", set_a, 3'b000);
        chk_v("rst_lost", lost_a, 3'b000);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // single event, two edges to strobe
        ienable_a = 3'b111;
        evt_a     = 3'b010;
        tick();
        evt_a = 3'b000;
        chk_b("single_lat", act_a, 1'b0);
        tick();
        chk_b("single_act", act_a, 1'b1);
        chk_v("single_set", set_a, 3'b010);
        tick();
        chk_b("single_end_act", act_a, 1'b0);
        chk_v("single_end_set", set_a, 3'b000);

        // simultaneous events, back-to-back fixed priority
        evt_a = 3'b111;
        tick();
        evt_a = 3'b000;
        tick();
        chk_b("sim0_act", act_a, 1'b1);
        chk_v("sim0_set", set_a, 3'b001);
        irqstd_a = 3'b001;
        tick();
        chk_b("sim1_act", act_a, 1'b1);
        chk_v("sim1_set", set_a, 3'b010);
        irqstd_a = 3'b011;
        tick();
        chk_b("sim2_act", act_a, 1'b1);
        chk_v("sim2_set", set_a, 3'b100);
        irqstd_a = 3'b111;
        tick();
        chk_b("sim_idle", act_a, 1'b0);
        chk_v("sim_idle_set", set_a, 3'b000);
        chk_b("irq_on", irq_a, 1'b1);
        irqstd_a = 3'b000;
        #1;
        chk_b("irq_off", irq_a, 1'b0);

        // set beats grant-clear: source 0 commits twice
        tick();
        evt_a = 3'b001;
        tick();
        tick();
        chk_b("sw_act0", act_a, 1'b1);
        chk_v("sw_set0", set_a, 3'b001);
        chk_v("sw_lost", lost_a, 3'b000);
        evt_a = 3'b000;
        tick();
        chk_b("sw_gap", act_a, 1'b0);
        tick();
        chk_b("sw_act1", act_a, 1'b1);
        chk_v("sw_set1", set_a, 3'b001);
        tick();
        chk_b("sw_end", act_a, 1'b0);

        // overrun from a pending, ungranted source
        evt_a = 3'b011;
        tick();
        evt_a = 3'b010;
        tick();
        evt_a = 3'b000;
        chk_v("po_set0", set_a, 3'b001);
        chk_v("po_lost", lost_a, 3'b010);
        tick();
        chk_v("po_set1", set_a, 3'b010);
        tick();
        chk_b("po_end", act_a, 1'b0);
        chk_v("po_lost_hold", lost_a, 3'b010);

        // new overrun wins over lostclr on the same edge
        irqstd_a = 3'b100;
        evt_a    = 3'b100;
        lostclr  = 1'b1;
        tick();
        evt_a = 3'b000;
        chk_v("lc_prio", lost_a, 3'b100);
        tick();
        lostclr  = 1'b0;
        irqstd_a = 3'b000;
        chk_v("lc_clr", lost_a, 3'b000);
        chk_b("lc_act", act_a, 1'b0);

        // event on a source already flagged
        irqstd_a = 3'b010;
        evt_a    = 3'b010;
        tick();
        evt_a = 3'b000;
        chk_v("ov_lost", lost_a, 3'b010);
        chk_b("ov_act0", act_a, 1'b0);
        tick();
        chk_b("ov_act1", act_a, 1'b0);
        irqstd_a = 3'b000;
        lostclr  = 1'b1;
        tick();
        lostclr = 1'b0;
        chk_v("ov_clr", lost_a, 3'b000);

        // masked source
        ienable_a = 3'b011;
        evt_a     = 3'b100;
        tick();
        evt_a = 3'b000;
        chk_v("mask_lost", lost_a, 3'b000);
        chk_b("mask_act0", act_a, 1'b0);
        tick();
        chk_b("mask_act1", act_a, 1'b0);

        // irq ignores ienable
        ienable_a = 3'b000;
        irqstd_a  = 3'b100;
        #1;
        chk_b("irq_nomask", irq_a, 1'b1);
        irqstd_a = 3'b000;
        #1;
        chk_b("irq_clear", irq_a, 1'b0);

        // asynchronous reset mid-commit
        tick();
        ienable_a = 3'b111;
        evt_a     = 3'b111;
        tick();
        tick();
        evt_a = 3'b000;
        chk_v("pre_rst_set", set_a, 3'b001);
        chk_v("pre_rst_lost", lost_a, 3'b110);
        #2;
        reset = 1'b0;
        #1;
        chk_b("arst_act", act_a, 1'b0);
        chk_v("arst_set", set_a, 3'b000);
        chk_v("arst_lost", lost_a, 3'b000);
        tick();
        reset = 1'b1;
        tick();
        chk_b("post_rst0", act_a, 1'b0);
        tick();
        chk_b("post_rst1", act_a, 1'b0);

        // round-robin alternation
        evt_b = 3'b101;
        tick();
        chk_b("rr_lat", act_b, 1'b0);
        tick();
        chk_v("rr_g1", set_b, 3'b100);
        tick();
        chk_v("rr_g2", set_b, 3'b001);
        chk_v("rr_lost", lost_b, 3'b101);
        tick();
        chk_v("rr_g3", set_b, 3'b100);
        tick();
        chk_v("rr_g4", set_b, 3'b001);
        tick();
        chk_v("rr_g5", set_b, 3'b100);
        evt_b = 3'b000;
        tick();
        chk_v("rr_g6", set_b, 3'b001);
        tick();
        chk_v("rr_g7", set_b, 3'b100);
        tick();
        chk_b("rr_idle", act_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
